db_mv_ram_ctrl: RTL and testbench
=================================

Name: db_mv_ram_ctrl

Overview:
Access controller for the 64x20 single-port deblocking MV RAM. It accepts random-address MV writes from the MV producer while idle. On command it sweeps all 64 entries in address order and streams them to the deblocking boundary-strength logic through a valid/ready interface. It owns the RAM's address, chip-enable and write-enable pins and handles the RAM's 1-cycle read latency with a 2-entry output buffer.

Parameters:
ADR_W, 6, RAM address width
DAT_W, 20, MV word width
DEPTH, 64, entries swept per read pass (2**ADR_W)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
wr_val_i  in  1  write request
wr_adr_i  in  ADR_W  write address
wr_dat_i  in  DAT_W  write data
wr_rdy_o  out  1  write accepted this cycle when high
rd_start_i  in  1  single-cycle pulse that starts a sweep
rd_busy_o  out  1  sweep or clear in progress
rd_done_o  out  1  single-cycle pulse when a sweep completes
rd_val_o  out  1  output word valid
rd_rdy_i  in  1  downstream ready
rd_adr_o  out  ADR_W  address of the current output word
rd_dat_o  out  DAT_W  output word
ram_adr_o  out  ADR_W  RAM address
ram_cen_o  out  1  RAM chip enable, low active
ram_wen_o  out  1  RAM write enable, low active
ram_wr_dat_o  out  DAT_W  RAM write data
ram_rd_dat_i  in  DAT_W  RAM read data, valid the cycle after a read issue

Behaviour:
- Single clock clk. Asynchronous active-low reset rstn. The reset value of each output is:
  - rd_val_o=0, rd_done_o=0, rd_busy_o=0
  - rd_dat_o=0, rd_adr_o=0
  - ram_cen_o=1, ram_wen_o=1, ram_adr_o=0, ram_wr_dat_o=0
  - wr_rdy_o=1
- Reset also puts the FSM in IDLE, clears the issue counter, the in-flight flag and the buffer. Reset mid-sweep drops all buffered data; no done pulse is generated.
- FSM states: IDLE, READ, DRAIN (plus CLR with the optional feature).
- IDLE:
  - wr_rdy_o=1.
  - When wr_val_i=1: ram_cen_o=0, ram_wen_o=0, ram_adr_o=wr_adr_i, ram_wr_dat_o=wr_dat_i, all combinational.
  - When rd_start_i=1: go to READ and clear the issue counter. A write in the same cycle is still performed.
- READ:
  - wr_rdy_o=0. Writes are held off and not lost by the producer.
  - A read issues when issue count < DEPTH and (buf_cnt + inflight − pop) < 2, where pop = rd_val_o & rd_rdy_i. This is a combinational path from rd_rdy_i to ram_cen_o and is permitted.
  - Issue drives ram_cen_o=0, ram_wen_o=1, ram_adr_o=issue count, then increments the count.
  - The in-flight flag captures ram_rd_dat_i and its address into the buffer on the next clock edge.
  - After the 64th issue, go to DRAIN.
- DRAIN:
  - When the buffer is empty and nothing is in flight, pulse rd_done_o for one cycle; the FSM is in IDLE in that same cycle.
- Output stream:
  - rd_val_o = buffer non-empty. The buffer head drives rd_dat_o and rd_adr_o.
  - While rd_val_o=1 and rd_rdy_i=0, rd_dat_o and rd_adr_o hold stable.
  - The buffer is a 2-entry FIFO and never overflows.
- rd_busy_o=1 in every state except IDLE. rd_start_i outside IDLE is ignored.
- Timing with rd_rdy_i held high and rd_start_i at cycle T:
  - issues at T+1..T+64
  - first rd_val_o at T+3
  - last pop at T+66
  - rd_done_o at T+67
  - wr_rdy_o=1 again at T+67
- Words are delivered in address order 0..63, each exactly once.

Optional Feature:
DB_MV_RAM_CLR_EN
- With the macro:
  - An extra input port clr_i (1 bit) exists.
  - In IDLE, a clr_i pulse enters CLR. clr_i has priority over rd_start_i; a same-cycle write still completes.
  - CLR writes DAT_W'b0 to addresses 0..63, one per cycle, for 64 cycles: ram_cen_o=0, ram_wen_o=0.
  - During CLR, rd_busy_o=1 and wr_rdy_o=0. rd_done_o is not pulsed. The FSM returns to IDLE after address 63.
- Without the macro: no clr_i port, no CLR state.

Test Plan:
- Write addresses 0..63 with data = 3*adr+5, then pulse rd_start_i at T with rd_rdy_i=1 → 64 words in order, rd_adr_o 0..63, first rd_val_o at T+3, rd_done_o single pulse at T+67.
- Random rd_rdy_i (50%), plus rd_rdy_i low for 10 cycles mid-sweep → no lost or duplicated words; rd_dat_o stable while stalled; at most 2 reads outstanding (buffer plus in flight).
- wr_val_i asserted during READ → wr_rdy_o=0 and the RAM is not written. rd_start_i and a write to adr 7 (data 0xABCDE) in the same IDLE cycle → the sweep returns 0xABCDE at adr 7.
- Second rd_start_i during READ and during DRAIN → ignored; exactly one rd_done_o per sweep.
- rstn low after 20 pops → all outputs take reset values immediately (asynchronously). A new sweep after release starts at adr 0 and returns all 64 words.
- DB_MV_RAM_CLR_EN defined: fill with non-zero data, pulse clr_i → ram_wen_o low for exactly 64 cycles with no rd_done_o; a following sweep returns 64 zeros.

Source files
------------

// File: rtl/db_mv_ram_ctrl_if.sv
// Bus bundle for db_mv_ram_ctrl: MV write port, read stream, RAM pins.
// DB_MV_RAM_CLR_EN adds the clr_i command.
interface db_mv_ram_ctrl_if #(
    parameter int unsigned ADR_W = 6,
    parameter int unsigned DAT_W = 20
);
    logic             wr_val_i;
    logic [ADR_W-1:0] wr_adr_i;
    logic [DAT_W-1:0] wr_dat_i;
    logic             wr_rdy_o;
    logic             rd_start_i;
    logic             rd_busy_o;
    logic             rd_done_o;
    logic             rd_val_o;
    logic             rd_rdy_i;
    logic [ADR_W-1:0] rd_adr_o;
    logic [DAT_W-1:0] rd_dat_o;
    logic [ADR_W-1:0] ram_adr_o;
    logic             ram_cen_o;
    logic             ram_wen_o;
    logic [DAT_W-1:0] ram_wr_dat_o;
    logic [DAT_W-1:0] ram_rd_dat_i;
`ifdef DB_MV_RAM_CLR_EN
    logic             clr_i;
`endif

    // Controller side
    modport slave (
`ifdef DB_MV_RAM_CLR_EN
        input  clr_i,
`endif
        input  wr_val_i, wr_adr_i, wr_dat_i, rd_start_i, rd_rdy_i, ram_rd_dat_i,
        output wr_rdy_o, rd_busy_o, rd_done_o, rd_val_o, rd_adr_o, rd_dat_o,
               ram_adr_o, ram_cen_o, ram_wen_o, ram_wr_dat_o
    );

    // Producer / consumer / RAM side
    modport master (
`ifdef DB_MV_RAM_CLR_EN
        output clr_i,
`endif
        output wr_val_i, wr_adr_i, wr_dat_i, rd_start_i, rd_rdy_i, ram_rd_dat_i,
        input  wr_rdy_o, rd_busy_o, rd_done_o, rd_val_o, rd_adr_o, rd_dat_o,
               ram_adr_o, ram_cen_o, ram_wen_o, ram_wr_dat_o
    );
endinterface

// File: rtl/db_mv_ram_ctrl.sv
// Deblocking MV RAM access controller: idle-time writes, address-ordered read sweep
// through a 2-entry output buffer. Optional zero-fill pass under DB_MV_RAM_CLR_EN.
module db_mv_ram_ctrl #(
    parameter int unsigned ADR_W = 6,
    parameter int unsigned DAT_W = 20
) (
    input  logic            clk,
    input  logic            rstn,
    db_mv_ram_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADR_W;
    localparam int unsigned CNT_W = ADR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
`ifdef DB_MV_RAM_CLR_EN
        ST_CLR,
`endif
        ST_DRAIN
    } state_t;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } ent_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             inflight;
    logic [ADR_W-1:0] infl_adr;
    ent_t             buf0;
    ent_t             buf1;
    logic [1:0]       buf_cnt;
    logic             done_q;

    logic             pop_c;
    logic             issue_c;
    logic [2:0]       occ_c;
    ent_t             push_ent_c;

    // Issue only if the word can still land in the buffer after this cycle's pop
    always_comb begin
        pop_c          = (buf_cnt != 2'd0) && bus.rd_rdy_i;
        push_ent_c.adr = infl_adr;
        push_ent_c.dat = bus.ram_rd_dat_i;
        occ_c          = 3'(buf_cnt) + 3'(inflight) - 3'(pop_c);
        issue_c        = (state == ST_READ) && (cnt < CNT_W'(DEPTH)) && (occ_c < 3'd2);
    end

    always_comb begin
        bus.ram_cen_o    = 1'b1;
        bus.ram_wen_o    = 1'b1;
        bus.ram_adr_o    = '0;
        bus.ram_wr_dat_o = '0;
        case (state)
            ST_IDLE: begin
                if (bus.wr_val_i) begin
                    bus.ram_cen_o    = 1'b0;
                    bus.ram_wen_o    = 1'b0;
                    bus.ram_adr_o    = bus.wr_adr_i;
                    bus.ram_wr_dat_o = bus.wr_dat_i;
                end
            end
            ST_READ: begin
                if (issue_c) begin
                    bus.ram_cen_o = 1'b0;
                    bus.ram_adr_o = cnt[ADR_W-1:0];
                end
            end
`ifdef DB_MV_RAM_CLR_EN
            ST_CLR: begin
                bus.ram_cen_o = 1'b0;
                bus.ram_wen_o = 1'b0;
                bus.ram_adr_o = cnt[ADR_W-1:0];
            end
`endif
            default: ;
        endcase
    end

    assign bus.wr_rdy_o  = (state == ST_IDLE);
    assign bus.rd_busy_o = (state != ST_IDLE);
    assign bus.rd_done_o = done_q;
    assign bus.rd_val_o  = (buf_cnt != 2'd0);
    assign bus.rd_adr_o  = buf0.adr;
    assign bus.rd_dat_o  = buf0.dat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            inflight <= 1'b0;
            infl_adr <= '0;
            buf0     <= '0;
            buf1     <= '0;
            buf_cnt  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= issue_c;
            if (issue_c) begin
                infl_adr <= cnt[ADR_W-1:0];
            end
            buf_cnt <= buf_cnt + 2'(inflight) - 2'(pop_c);

            // buf0 is the head; the word read last cycle lands behind whatever survives the pop
            if (inflight && pop_c) begin
                if (buf_cnt == 2'd2) begin
                    buf0 <= buf1;
                    buf1 <= push_ent_c;
                end else begin
                    buf0 <= push_ent_c;
                end
            end else if (pop_c) begin
                buf0 <= buf1;
            end else if (inflight) begin
                if (buf_cnt == 2'd0) begin
                    buf0 <= push_ent_c;
                end else begin
                    buf1 <= push_ent_c;
                end
            end

            case (state)
                ST_IDLE: begin
`ifdef DB_MV_RAM_CLR_EN
                    if (bus.clr_i) begin
                        state <= ST_CLR;
                        cnt   <= '0;
                    end else
`endif
                    if (bus.rd_start_i) begin
                        state <= ST_READ;
                        cnt   <= '0;
                    end
                end
                ST_READ: begin
                    if (issue_c) begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(DEPTH - 1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave when the buffer empties at this edge so done and IDLE coincide
                    if (!inflight && (buf_cnt == 2'(pop_c))) begin
                        state  <= ST_IDLE;
                        done_q <= 1'b1;
                    end
                end
`ifdef DB_MV_RAM_CLR_EN
                ST_CLR: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DEPTH - 1)) begin
                        state <= ST_IDLE;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_db_mv_ram_ctrl.sv
// Randomized self-checking bench for db_mv_ram_ctrl: RAM model plus an
// address-ordered expected stream built from a shadow copy of the RAM contents.
module tb_db_mv_ram_ctrl;
    localparam int unsigned ADR_W = 6;
    localparam int unsigned DAT_W = 20;
    localparam int          DEPTH = 64;

    logic clk;
    logic rstn;

    db_mv_ram_ctrl_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    db_mv_ram_ctrl #(.ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with one cycle read latency
    logic [DAT_W-1:0] ram [DEPTH];
    logic [DAT_W-1:0] ram_q;
    always @(posedge clk) begin
        if (!bus.ram_cen_o) begin
            if (!bus.ram_wen_o) ram[bus.ram_adr_o] <= bus.ram_wr_dat_o;
            else                ram_q <= ram[bus.ram_adr_o];
        end
    end
    assign bus.ram_rd_dat_i = ram_q;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int               n_checks;
    int               n_errors;
    logic [DAT_W-1:0] exp_mem [DEPTH];
    int               exp_adr_q [$];
    logic [DAT_W-1:0] exp_dat_q [$];
    int               issued, popped, done_cnt, wr_strobes, max_out;
    int               first_val_cyc, last_pop_cyc, done_cyc;
    bit               rdy_at_done;
    bit               mon_en;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle: head word must equal the next expected word; reads must follow address order
    always @(negedge clk) begin
        int out_now;
        if (rstn && mon_en) begin
            out_now = issued - popped;
            if (out_now > max_out) max_out = out_now;
            if (!bus.ram_cen_o && bus.ram_wen_o) begin
                chk("issue_adr", 32'(bus.ram_adr_o), 32'(issued));
                issued++;
            end
            if (!bus.ram_cen_o && !bus.ram_wen_o) wr_strobes++;
            if (bus.rd_val_o) begin
                if (first_val_cyc < 0) first_val_cyc = cyc;
                chk("val_expected", 32'(exp_adr_q.size() != 0), 32'd1);
                if (exp_adr_q.size() != 0) begin
                    chk("rd_adr", 32'(bus.rd_adr_o), 32'(exp_adr_q[0]));
                    chk("rd_dat", 32'(bus.rd_dat_o), 32'(exp_dat_q[0]));
                    if (bus.rd_rdy_i) begin
                        void'(exp_adr_q.pop_front());
                        void'(exp_dat_q.pop_front());
                        popped++;
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (bus.rd_done_o) begin
                done_cnt++;
                done_cyc    = cyc;
                rdy_at_done = bus.wr_rdy_o;
            end
        end
    end

    task automatic clr_mon();
        issued = 0; popped = 0; done_cnt = 0; wr_strobes = 0; max_out = 0;
        first_val_cyc = -1; last_pop_cyc = -1; done_cyc = -1; rdy_at_done = 1'b0;
    endtask

    task automatic build_exp();
        exp_adr_q.delete();
        exp_dat_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            exp_adr_q.push_back(a);
            exp_dat_q.push_back(exp_mem[a]);
        end
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_rd_val"},    32'(bus.rd_val_o),     32'd0);
        chk({p, "_rd_done"},   32'(bus.rd_done_o),    32'd0);
        chk({p, "_rd_busy"},   32'(bus.rd_busy_o),    32'd0);
        chk({p, "_rd_dat"},    32'(bus.rd_dat_o),     32'd0);
        chk({p, "_rd_adr"},    32'(bus.rd_adr_o),     32'd0);
        chk({p, "_ram_cen"},   32'(bus.ram_cen_o),    32'd1);
        chk({p, "_ram_wen"},   32'(bus.ram_wen_o),    32'd1);
        chk({p, "_ram_adr"},   32'(bus.ram_adr_o),    32'd0);
        chk({p, "_ram_wdat"},  32'(bus.ram_wr_dat_o), 32'd0);
        chk({p, "_wr_rdy"},    32'(bus.wr_rdy_o),     32'd1);
    endtask

    // One write per call; caller drops wr_val_i afterwards
    task automatic wr(input int a, input logic [DAT_W-1:0] d);
        @(posedge clk); #1;
        bus.wr_val_i = 1'b1;
        bus.wr_adr_i = ADR_W'(a);
        bus.wr_dat_i = d;
        exp_mem[a]   = d;
        @(negedge clk);
        chk("wr_rdy_idle", 32'(bus.wr_rdy_o), 32'd1);
    endtask

    task automatic wr_end();
        @(posedge clk); #1;
        bus.wr_val_i = 1'b0;
    endtask

    task automatic run_sweep(input string name, input bit rnd_rdy, input bit extra,
                             input bit wr_mid, input bit wr7, input bit timing);
        int t0;
        int rel;
        bit dr_pulsed;
        clr_mon();
        @(posedge clk); #1;
        bus.rd_start_i = 1'b1;
        bus.rd_rdy_i   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (wr7) begin
            bus.wr_val_i = 1'b1;
            bus.wr_adr_i = ADR_W'(7);
            bus.wr_dat_i = DAT_W'(20'hABCDE);
            exp_mem[7]   = DAT_W'(20'hABCDE);
        end
        build_exp();
        t0 = cyc;
        dr_pulsed = 1'b0;
        for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            if (k == 0) wr_strobes = 0;
            rel = cyc - t0;
            bus.rd_start_i = 1'b0;
            bus.wr_val_i   = 1'b0;
            if (rnd_rdy) bus.rd_rdy_i = (rel >= 20 && rel < 30) ? 1'b0 : 1'($urandom_range(0, 1));
            else         bus.rd_rdy_i = 1'b1;
            if (extra && rel == 10) bus.rd_start_i = 1'b1;
            if (extra && !dr_pulsed && issued == DEPTH) begin
                bus.rd_start_i = 1'b1;
                dr_pulsed = 1'b1;
            end
            if (wr_mid && rel == 5) begin
                bus.wr_val_i = 1'b1;
                bus.wr_adr_i = ADR_W'($urandom_range(0, DEPTH - 1));
                bus.wr_dat_i = DAT_W'($urandom);
                @(negedge clk);
                chk({name, "_wr_rdy_busy"}, 32'(bus.wr_rdy_o), 32'd0);
            end
        end
        chk({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        bus.rd_start_i = 1'b0;
        bus.wr_val_i   = 1'b0;
        bus.rd_rdy_i   = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({name, "_done_cnt"},   32'(done_cnt),          32'd1);
        chk({name, "_popped"},     32'(popped),            32'(DEPTH));
        chk({name, "_issued"},     32'(issued),            32'(DEPTH));
        chk({name, "_left"},       32'(exp_adr_q.size()),  32'd0);
        chk({name, "_out_le2"},    32'(max_out <= 2),      32'd1);
        chk({name, "_no_ram_wr"},  32'(wr_strobes),        32'd0);
        chk({name, "_busy_after"}, 32'(bus.rd_busy_o),     32'd0);
        chk({name, "_rdy_after"},  32'(bus.wr_rdy_o),      32'd1);
        if (timing) begin
            chk({name, "_first_val"}, 32'(first_val_cyc - t0), 32'd3);
            chk({name, "_last_pop"},  32'(last_pop_cyc - t0),  32'd66);
            chk({name, "_done_at"},   32'(done_cyc - t0),      32'd67);
            chk({name, "_rdy_done"},  32'(rdy_at_done),        32'd1);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        mon_en   = 1'b0;
        clr_mon();
        rstn = 1'b0;
        bus.wr_val_i   = 1'b0;
        bus.wr_adr_i   = '0;
        bus.wr_dat_i   = '0;
        bus.rd_start_i = 1'b0;
        bus.rd_rdy_i   = 1'b0;
`ifdef DB_MV_RAM_CLR_EN
        bus.clr_i      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst_hold");
        @(negedge clk); #2;
        rstn = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_release");
        mon_en = 1'b1;

        for (int a = 0; a < DEPTH; a++) wr(a, DAT_W'(3 * a + 5));
        wr_end();
        run_sweep("basic", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_sweep("stall", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) wr($urandom_range(0, DEPTH - 1), DAT_W'($urandom));
        wr_end();
        run_sweep("wr7", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of a sweep
        clr_mon();
        build_exp();
        @(posedge clk); #1;
        bus.rd_start_i = 1'b1;
        bus.rd_rdy_i   = 1'b1;
        @(posedge clk); #1;
        bus.rd_start_i = 1'b0;
        for (int k = 0; k < 200 && popped < 20; k++) @(posedge clk);
        chk("rst_pops_reached", 32'(popped >= 20), 32'd1);
        @(negedge clk); #2;
        rstn = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_adr_q.delete();
        exp_dat_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk); #2;
        rstn = 1'b1;
        run_sweep("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef DB_MV_RAM_CLR_EN
        for (int a = 0; a < DEPTH; a++) wr(a, DAT_W'($urandom) | DAT_W'(1));
        wr_end();
        @(posedge clk); #1;
        clr_mon();
        bus.clr_i = 1'b1;
        @(posedge clk); #1;
        bus.clr_i = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("clr_busy",   32'(bus.rd_busy_o), 32'd1);
        chk("clr_wr_rdy", 32'(bus.wr_rdy_o),  32'd0);
        repeat (70) @(posedge clk);
        @(negedge clk);
        chk("clr_writes", 32'(wr_strobes),    32'(DEPTH));
        chk("clr_done",   32'(done_cnt),      32'd0);
        chk("clr_idle",   32'(bus.rd_busy_o), 32'd0);
        for (int a = 0; a < DEPTH; a++) exp_mem[a] = '0;
        run_sweep("after_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
